hazard_forward_unit: RTL and testbench
======================================

Name: hazard_forward_unit

Overview:
- Next-generation forwarding unit for the pipelined core.
- Register-address width is parametrised.
- Forwarding select for each ID source operand: EX/MEM, MEM/WB, or the completing multi-cycle multiplier.
- Adds load-use stall detection and a one-entry scoreboard that tracks a non-pipelined multi-cycle multiply.
- Sits beside the ID stage and drives the operand muxes and the pipeline stall line.

Parameters:
- REG_ADDR_W, 3: register-address width; register 0 is hardwired zero and is never forwarded or tracked.
- MUL_LAT, 3: multiplier latency in cycles; legal range 2..15.
- CNT_W, 16: width of the stall performance counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  pipeline flush; kills the in-flight multiply.
- id_valid  in  1  ID holds a valid instruction.
- id_rs, id_rt  in  REG_ADDR_W  ID source registers.
- id_rs_used, id_rt_used  in  1  source operand actually read.
- id_regwr  in  1  ID instruction writes a register.
- id_dst  in  REG_ADDR_W  ID destination.
- id_is_mul  in  1  ID instruction is a multiply.
- id_ex_memrd  in  1  instruction in EX is a load.
- id_ex_dst  in  REG_ADDR_W  destination of the instruction in EX.
- ex_mem_regwr, mem_wb_regwr  in  1  write enables of the later stages.
- ex_mem_dst, mem_wb_dst  in  REG_ADDR_W  destinations of the later stages.
- fa, fb  out  2  forwarding selects: 00 regfile, 01 MEM/WB, 10 EX/MEM, 11 multiplier result.
- stall  out  1  hold IF/ID, insert bubble.
- mul_busy  out  1  scoreboard entry valid.
- mul_done  out  1  multiplier result valid this cycle.
- mul_dst  out  REG_ADDR_W  tracked destination.
- stall_cnt  out  CNT_W  stall cycle count.

Behaviour:
- Reset (asynchronous, active-high) clears mul_busy, the countdown counter, mul_dst and stall_cnt. Combinational outputs then follow the inputs: no stall unless a load-use hazard is present on the inputs.
- A match requires a nonzero destination and the corresponding source-used bit set.
- fa priority (fb identical using id_rt):
  - 11 if mul_done and mul_dst==id_rs;
  - else 10 if ex_mem_regwr and ex_mem_dst==id_rs;
  - else 01 if mem_wb_regwr and mem_wb_dst==id_rs;
  - else 00.
  - Selects are purely combinational, zero latency.
- Busy window: busy = mul_busy and not mul_done.
- stall = id_valid and any of:
  - load-use: id_ex_memrd and id_ex_dst!=0 and id_ex_dst matches a used source;
  - RAW: busy and mul_dst matches a used source;
  - WAW: busy and id_regwr and id_dst==mul_dst;
  - structural: busy and id_is_mul.
- Scoreboard states:
  - IDLE (mul_busy=0).
  - BUSY: counter counts MUL_LAT down to 1.
  - mul_done = mul_busy and counter==1.
- Issue: a multiply issued in cycle T (id_valid, id_is_mul, !stall, !flush, id_dst!=0) at the clock edge:
  - sets mul_busy;
  - loads counter=MUL_LAT and mul_dst=id_dst.
  - The machine is busy in cycles T+1..T+MUL_LAT; mul_done is high only in cycle T+MUL_LAT.
- In the done cycle:
  - dependents forward with select 11 and do not stall;
  - a new multiply may issue, which reloads the counter back-to-back;
  - with no issue, the entry clears at the edge.
- A multiply with id_dst==0 is not tracked.
- flush: synchronous, highest priority.
  - Clears mul_busy and the counter at the edge.
  - Overrides a simultaneous issue or done.
  - mul_done is suppressed in the flush cycle.
- stall_cnt increments at each edge where stall=1 and saturates at all-ones; flush does not clear it.
- Reset asserted mid-multiply drops mul_busy immediately and asynchronously; no mul_done is produced.

Optional Feature:
- HAZARD_STALL_CNT_EN
  - Defined: stall_cnt is implemented as above.
  - Undefined: no counter flops; stall_cnt is tied to 0.

Test Plan:
- EX/MEM and MEM/WB both write r3, ID reads r3 as rs -> fa=10. With ex_mem_regwr=0 -> fa=01. With dst=0 on both -> fa=00.
- Load to r2 in EX, ID reads r2 as rt with id_rt_used=1 -> stall=1 for that cycle, fb=00. With id_rt_used=0 -> stall=0.
- MUL_LAT=3: multiply to r5 issues at T -> mul_busy=1 for T+1..T+3, mul_done=1 only at T+3. A reader of r5 at T+1 and T+2 -> stall=1. At T+3 -> stall=0, fa=11.
- Second multiply presented at T+2 -> stall=1. Presented at T+3 -> accepted, mul_done pulses again at T+6.
- flush at T+2 with a multiply in flight -> mul_busy=0 at T+3, no mul_done, a reader of r5 is not stalled.
- With HAZARD_STALL_CNT_EN defined, 4 load-use stalls then reset -> stall_cnt=4 before reset, 0 after. Undefined -> stall_cnt stays 0.

Source files
------------

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
//
// Forwarding and hazard unit that sits beside the ID stage. It drives the ID
// operand muxes and the pipeline stall line. It also keeps a one-entry
// scoreboard for the non-pipelined multi-cycle multiplier.
//
// Ports:
//   clk, reset           clock; asynchronous active-high reset
//   flush                pipeline flush, kills an in-flight multiply
//   id_valid             ID holds a valid instruction
//   id_rs, id_rt         ID source registers
//   id_rs_used/rt_used   source operand is actually read
//   id_regwr, id_dst     ID instruction writes register id_dst
//   id_is_mul            ID instruction is a multiply
//   id_ex_memrd/dst      instruction in EX is a load to id_ex_dst
//   ex_mem_regwr/dst     EX/MEM write enable and destination
//   mem_wb_regwr/dst     MEM/WB write enable and destination
//   fa, fb               operand selects: 00 regfile, 01 MEM/WB, 10 EX/MEM,
//                        11 multiplier result
//   stall                hold IF/ID and insert a bubble
//   mul_busy             scoreboard entry valid
//   mul_done             multiplier result valid this cycle
//   mul_dst              destination tracked by the scoreboard
//   stall_cnt            saturating count of stall cycles
//
// Optional feature macro: HAZARD_STALL_CNT_EN
//   defined   -> stall_cnt is a saturating counter of stall cycles
//   undefined -> no counter flops; stall_cnt is tied to zero
//
// Register 0 is hardwired zero, so it is never forwarded and never tracked.

module hazard_forward_unit #(
    parameter int REG_ADDR_W = 3,
    parameter int MUL_LAT    = 3,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_rs_used,
    input  logic                  id_rt_used,
    input  logic                  id_regwr,
    input  logic [REG_ADDR_W-1:0] id_dst,
    input  logic                  id_is_mul,
    input  logic                  id_ex_memrd,
    input  logic [REG_ADDR_W-1:0] id_ex_dst,
    input  logic                  ex_mem_regwr,
    input  logic                  mem_wb_regwr,
    input  logic [REG_ADDR_W-1:0] ex_mem_dst,
    input  logic [REG_ADDR_W-1:0] mem_wb_dst,
    output logic [1:0]            fa,
    output logic [1:0]            fb,
    output logic                  stall,
    output logic                  mul_busy,
    output logic                  mul_done,
    output logic [REG_ADDR_W-1:0] mul_dst,
    output logic [CNT_W-1:0]      stall_cnt
);

    // Four bits cover the whole legal latency range (2..15).
    localparam int LAT_W = 4;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MUL_LAT);
    localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);

    typedef enum logic {
        SB_IDLE,
        SB_BUSY
    } sb_state_t;

    sb_state_t             state_q, state_d;
    logic [LAT_W-1:0]      cnt_q, cnt_d;
    logic [REG_ADDR_W-1:0] dst_q, dst_d;

    logic busy;
    logic issue;
    logic load_use, mul_raw, mul_waw, mul_struct;

    // A producer matches a consumer only if it really writes a nonzero
    // register and the consumer really reads that operand.
    function automatic logic hit(
        input logic                  wr_en,
        input logic [REG_ADDR_W-1:0] dst,
        input logic [REG_ADDR_W-1:0] src,
        input logic                  used
    );
        return wr_en && (dst != '0) && used && (dst == src);
    endfunction

    assign mul_busy = (state_q == SB_BUSY);
    assign mul_dst  = dst_q;

    // The result comes out on the last count. A flush in the same cycle
    // squashes it, so no dependent may consume it.
    assign mul_done = mul_busy && (cnt_q == LAT_ONE) && !flush;

    // In the done cycle the result is forwardable, so the entry stops
    // blocking dependents and a new multiply.
    assign busy = mul_busy && !mul_done;

    // Hazard terms
    assign load_use   = hit(id_ex_memrd, id_ex_dst, id_rs, id_rs_used) ||
                        hit(id_ex_memrd, id_ex_dst, id_rt, id_rt_used);
    assign mul_raw    = busy && (hit(1'b1, dst_q, id_rs, id_rs_used) ||
                                 hit(1'b1, dst_q, id_rt, id_rt_used));
    assign mul_waw    = busy && id_regwr && (id_dst == dst_q);
    assign mul_struct = busy && id_is_mul;

    assign stall = id_valid && (load_use || mul_raw || mul_waw || mul_struct);

    // A multiply to r0 produces nothing observable, so it is not tracked.
    assign issue = id_valid && id_is_mul && !stall && !flush && (id_dst != '0);

    // Operand selects. The multiplier result is newest, then EX/MEM, then
    // MEM/WB. They are purely combinational so they apply in the same cycle.
    always_comb begin
        fa = 2'b00;
        fb = 2'b00;
        if (mul_done && hit(1'b1, dst_q, id_rs, id_rs_used))
            fa = 2'b11;
        else if (hit(ex_mem_regwr, ex_mem_dst, id_rs, id_rs_used))
            fa = 2'b10;
        else if (hit(mem_wb_regwr, mem_wb_dst, id_rs, id_rs_used))
            fa = 2'b01;

        if (mul_done && hit(1'b1, dst_q, id_rt, id_rt_used))
            fb = 2'b11;
        else if (hit(ex_mem_regwr, ex_mem_dst, id_rt, id_rt_used))
            fb = 2'b10;
        else if (hit(mem_wb_regwr, mem_wb_dst, id_rt, id_rt_used))
            fb = 2'b01;
    end

    // Scoreboard next state. Flush wins over everything. An issue in the
    // done cycle reloads the countdown back-to-back. Otherwise the count
    // runs down and the entry clears after the done cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dst_d   = dst_q;
        if (flush) begin
            state_d = SB_IDLE;
            cnt_d   = '0;
        end else if (issue) begin
            state_d = SB_BUSY;
            cnt_d   = LAT_LOAD;
            dst_d   = id_dst;
        end else if (state_q == SB_BUSY) begin
            if (cnt_q == LAT_ONE) begin
                state_d = SB_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q - LAT_ONE;
            end
        end
    end

    // Scoreboard registers. Reset drops the entry at once, so a multiply
    // that is in flight when reset hits never signals completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SB_IDLE;
            cnt_q   <= '0;
            dst_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dst_q   <= dst_d;
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;

    // The stall counter saturates instead of wrapping. It is a performance
    // statistic, so flush leaves it alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cnt_q <= '0;
        else if (stall && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit
//
// Directed, self-checking bench for hazard_forward_unit with REG_ADDR_W=3,
// MUL_LAT=3 and CNT_W=16. Inputs change 1 ns after a rising edge. Outputs
// are sampled on the following falling edge.

module tb_hazard_forward_unit;

    localparam int W = 3;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          id_valid;
    logic [W-1:0]  id_rs, id_rt;
    logic          id_rs_used, id_rt_used;
    logic          id_regwr;
    logic [W-1:0]  id_dst;
    logic          id_is_mul;
    logic          id_ex_memrd;
    logic [W-1:0]  id_ex_dst;
    logic          ex_mem_regwr, mem_wb_regwr;
    logic [W-1:0]  ex_mem_dst, mem_wb_dst;
    logic [1:0]    fa, fb;
    logic          stall, mul_busy, mul_done;
    logic [W-1:0]  mul_dst;
    logic [CW-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    hazard_forward_unit #(.REG_ADDR_W(W), .MUL_LAT(3), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .flush(flush), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used),
        .id_rt_used(id_rt_used), .id_regwr(id_regwr), .id_dst(id_dst),
        .id_is_mul(id_is_mul), .id_ex_memrd(id_ex_memrd),
        .id_ex_dst(id_ex_dst), .ex_mem_regwr(ex_mem_regwr),
        .mem_wb_regwr(mem_wb_regwr), .ex_mem_dst(ex_mem_dst),
        .mem_wb_dst(mem_wb_dst), .fa(fa), .fb(fb), .stall(stall),
        .mul_busy(mul_busy), .mul_done(mul_done), .mul_dst(mul_dst),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task clear_inputs;
        flush = 0; id_valid = 0; id_rs = 0; id_rt = 0;
        id_rs_used = 0; id_rt_used = 0; id_regwr = 0; id_dst = 0;
        id_is_mul = 0; id_ex_memrd = 0; id_ex_dst = 0;
        ex_mem_regwr = 0; mem_wb_regwr = 0; ex_mem_dst = 0; mem_wb_dst = 0;
    endtask

    // Advance to 1 ns past the next rising edge and return to idle inputs.
    task next_cycle;
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    // Present a multiply writing dst.
    task drive_mul(input logic [W-1:0] dst);
        id_valid = 1; id_is_mul = 1; id_regwr = 1; id_dst = dst;
    endtask

    // Present an instruction that reads src as rs.
    task drive_reader(input logic [W-1:0] src);
        id_valid = 1; id_rs = src; id_rs_used = 1;
    endtask

    task test_reset;
        clear_inputs();
        reset = 1;
        #3;
        checks++;
        if (mul_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", mul_busy); end
        checks++;
        if (mul_dst !== 3'd0) begin errors++; $display("FAIL reset_dst got %0d want 0", mul_dst); end
        checks++;
        if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", stall_cnt); end
        checks++;
        if (stall !== 1'b0 || fa !== 2'b00) begin errors++; $display("FAIL reset_comb got stall=%0b fa=%0b want 0/00", stall, fa); end
        @(posedge clk);
        #1 reset = 0;
    endtask

    task test_forwarding;
        next_cycle();
        id_valid = 1; id_rs = 3; id_rs_used = 1; id_rt = 3; id_rt_used = 1;
        ex_mem_regwr = 1; ex_mem_dst = 3; mem_wb_regwr = 1; mem_wb_dst = 3;
        #4;
        checks++;
        if (fa !== 2'b10 || fb !== 2'b10) begin errors++; $display("FAIL fwd_exmem got fa=%b fb=%b want 10/10", fa, fb); end
        ex_mem_regwr = 0;
        #1;
        checks++;
        if (fa !== 2'b01) begin errors++; $display("FAIL fwd_memwb got fa=%b want 01", fa); end
        id_rt_used = 0;
        #1;
        checks++;
        if (fb !== 2'b00) begin errors++; $display("FAIL fwd_rt_unused got fb=%b want 00", fb); end
        ex_mem_regwr = 1; ex_mem_dst = 0; mem_wb_dst = 0; id_rs = 0;
        #1;
        checks++;
        if (fa !== 2'b00) begin errors++; $display("FAIL fwd_r0 got fa=%b want 00", fa); end
    endtask

    task test_load_use;
        next_cycle();
        id_valid = 1; id_rt = 2; id_rt_used = 1;
        id_ex_memrd = 1; id_ex_dst = 2;
        #4;
        checks++;
        if (stall !== 1'b1 || fb !== 2'b00) begin errors++; $display("FAIL load_use got stall=%0b fb=%b want 1/00", stall, fb); end
        id_rt_used = 0;
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL load_use_unused got %0b want 0", stall); end
        id_rt_used = 1; id_valid = 0;
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL load_use_invalid got %0b want 0", stall); end
        id_valid = 1; id_rt = 0; id_ex_dst = 0;
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL load_use_r0 got %0b want 0", stall); end
    endtask

    task test_mul_scoreboard;
        next_cycle();
        drive_mul(5);
        #4;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL mul_issue_stall got %0b want 0", stall); end
        for (int k = 1; k <= 2; k++) begin
            next_cycle();
            drive_reader(5);
            #4;
            checks++;
            if (mul_busy !== 1'b1 || mul_done !== 1'b0 || stall !== 1'b1 || mul_dst !== 3'd5) begin
                errors++;
                $display("FAIL mul_wait%0d got busy=%0b done=%0b stall=%0b dst=%0d want 1/0/1/5",
                         k, mul_busy, mul_done, stall, mul_dst);
            end
        end
        next_cycle();
        drive_reader(5);
        #4;
        checks++;
        if (mul_done !== 1'b1 || stall !== 1'b0 || fa !== 2'b11) begin
            errors++;
            $display("FAIL mul_done got done=%0b stall=%0b fa=%b want 1/0/11", mul_done, stall, fa);
        end
        next_cycle();
        #4;
        checks++;
        if (mul_busy !== 1'b0) begin errors++; $display("FAIL mul_clear got %0b want 0", mul_busy); end
    endtask

    task test_waw_and_r0;
        next_cycle();
        drive_mul(5);
        next_cycle();
        id_valid = 1; id_regwr = 1; id_dst = 5;
        #4;
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL waw got %0b want 1", stall); end
        next_cycle();
        id_valid = 1; id_rs = 5; id_rs_used = 0; id_regwr = 1; id_dst = 4;
        #4;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL busy_indep got %0b want 0", stall); end
        next_cycle();
        next_cycle();
        drive_mul(0);
        next_cycle();
        #4;
        checks++;
        if (mul_busy !== 1'b0) begin errors++; $display("FAIL mul_r0 got busy=%0b want 0", mul_busy); end
    endtask

    task test_back_to_back;
        next_cycle();
        drive_mul(5);
        next_cycle();
        next_cycle();
        drive_mul(6);
        #4;
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL b2b_struct got %0b want 1", stall); end
        next_cycle();
        drive_mul(6);
        #4;
        checks++;
        if (stall !== 1'b0 || mul_done !== 1'b1) begin errors++; $display("FAIL b2b_accept got stall=%0b done=%0b want 0/1", stall, mul_done); end
        for (int k = 4; k <= 5; k++) begin
            next_cycle();
            #4;
            checks++;
            if (mul_busy !== 1'b1 || mul_done !== 1'b0 || mul_dst !== 3'd6) begin
                errors++;
                $display("FAIL b2b_T%0d got busy=%0b done=%0b dst=%0d want 1/0/6", k, mul_busy, mul_done, mul_dst);
            end
        end
        next_cycle();
        #4;
        checks++;
        if (mul_done !== 1'b1) begin errors++; $display("FAIL b2b_done2 got %0b want 1", mul_done); end
        next_cycle();
        #4;
        checks++;
        if (mul_busy !== 1'b0) begin errors++; $display("FAIL b2b_clear got %0b want 0", mul_busy); end
    endtask

    task test_flush;
        next_cycle();
        drive_mul(5);
        next_cycle();
        next_cycle();
        flush = 1;
        #4;
        checks++;
        if (mul_done !== 1'b0) begin errors++; $display("FAIL flush_done got %0b want 0", mul_done); end
        next_cycle();
        drive_reader(5);
        #4;
        checks++;
        if (mul_busy !== 1'b0 || stall !== 1'b0 || mul_done !== 1'b0) begin
            errors++;
            $display("FAIL flush_after got busy=%0b stall=%0b done=%0b want 0/0/0", mul_busy, stall, mul_done);
        end
        // Flush landing on the done cycle, with a new multiply offered.
        next_cycle();
        drive_mul(5);
        next_cycle();
        next_cycle();
        next_cycle();
        flush = 1; drive_mul(4);
        #4;
        checks++;
        if (mul_done !== 1'b0) begin errors++; $display("FAIL flush_on_done got %0b want 0", mul_done); end
        next_cycle();
        #4;
        checks++;
        if (mul_busy !== 1'b0) begin errors++; $display("FAIL flush_kills_issue got %0b want 0", mul_busy); end
    endtask

    task test_reset_mid_mul;
        next_cycle();
        drive_mul(5);
        next_cycle();
        #2 reset = 1;
        #1;
        checks++;
        if (mul_busy !== 1'b0 || mul_done !== 1'b0 || mul_dst !== 3'd0) begin
            errors++;
            $display("FAIL reset_async got busy=%0b done=%0b dst=%0d want 0/0/0", mul_busy, mul_done, mul_dst);
        end
        @(posedge clk);
        #1 reset = 0;
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            #4;
            checks++;
            if (mul_done !== 1'b0) begin errors++; $display("FAIL reset_no_done%0d got %0b want 0", k, mul_done); end
        end
    endtask

    task test_stall_cnt;
        logic [CW-1:0] exp_cnt;
`ifdef HAZARD_STALL_CNT_EN
        exp_cnt = 16'd4;
`else
        exp_cnt = 16'd0;
`endif
        next_cycle();
        reset = 1;
        #2 reset = 0;
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            id_valid = 1; id_rs = 2; id_rs_used = 1; id_ex_memrd = 1; id_ex_dst = 2;
        end
        next_cycle();
        flush = 1;
        #4;
        checks++;
        if (stall_cnt !== exp_cnt) begin errors++; $display("FAIL stall_cnt got %0d want %0d", stall_cnt, exp_cnt); end
        next_cycle();
        #4;
        checks++;
        if (stall_cnt !== exp_cnt) begin errors++; $display("FAIL stall_cnt_flush got %0d want %0d", stall_cnt, exp_cnt); end
        reset = 1;
        #1;
        checks++;
        if (stall_cnt !== 16'd0) begin errors++; $display("FAIL stall_cnt_reset got %0d want 0", stall_cnt); end
        #1 reset = 0;
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_mul_scoreboard();
        test_waw_and_r0();
        test_back_to_back();
        test_flush();
        test_reset_mid_mul();
        test_stall_cnt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
